// File: rtl/flash_rd_ctrl.sv
// Read-only CPU-to-parallel-NOR-flash bridge: assembles 32-bit words from
// FLASH_DW-wide beats with WAIT_CYC cycles per beat, and keeps a one-word read buffer.
module flash_rd_ctrl #(
  parameter int FLASH_DW = 8,
  parameter int WAIT_CYC = 3,
  parameter int ADDR_W   = 22
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [31:0]         adr_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic                inv_i,
  output logic [31:0]         dat_o,
  output logic                ready_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   flash_adr_o,
  input  logic [FLASH_DW-1:0] flash_dat_i,
  output logic                flash_ce,
  output logic                flash_oe,
  output logic                flash_we,
  output logic                flash_rst
);

  localparam int BEATS = 32 / FLASH_DW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]        state;
  logic [31:0]       rd_buf;
  logic [ADDR_W-3:0] tag;
  logic [ADDR_W-3:0] word_idx;
  logic              valid;
  logic              kill;
  logic [2:0]        beat;
  logic [3:0]        wcnt;
  logic              last_wait;
  logic              last_beat;

  assign word_idx  = adr_i[ADDR_W-1:2];
  assign last_wait = (wcnt == 4'(WAIT_CYC - 1));
  assign last_beat = (beat == 3'(BEATS - 1));

  generate
    if (ADDR_W < 32) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^adr_i[31:ADDR_W];
    end
  endgenerate
  logic unused_lo;
  assign unused_lo = ^adr_i[1:0];

  function automatic logic [ADDR_W-1:0] beat_adr(input logic [ADDR_W-3:0] wi,
                                                 input logic [2:0] b);
    return ADDR_W'(wi) * ADDR_W'(BEATS) + ADDR_W'(b);
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      rd_buf      <= '0;
      tag         <= '0;
      valid       <= 1'b0;
      kill        <= 1'b0;
      beat        <= '0;
      wcnt        <= '0;
      flash_adr_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (stb_i) begin
            if (we_i) begin
              state <= S_ERR;
            end else if (valid && (tag == word_idx) && !inv_i) begin
              state <= S_ACK;
            end else begin
              state       <= S_READ;
              beat        <= '0;
              wcnt        <= '0;
              kill        <= inv_i;
              flash_adr_o <= beat_adr(word_idx, 3'd0);
            end
          end
        end
        S_READ: begin
          if (!stb_i) begin
            state <= S_IDLE;
            valid <= 1'b0;
          end else if (last_wait) begin
            // beat 0 lands in the most significant lane
            for (int unsigned k = 0; k < BEATS; k++) begin
              if (beat == 3'(k)) rd_buf[31 - k*FLASH_DW -: FLASH_DW] <= flash_dat_i;
            end
            wcnt        <= '0;
            beat        <= beat + 3'd1;
            flash_adr_o <= beat_adr(word_idx, beat + 3'd1);
            if (last_beat) begin
              state <= S_ACK;
              tag   <= word_idx;
              valid <= !(kill || inv_i);
            end
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (inv_i) begin
        valid <= 1'b0;
        if (state == S_READ) kill <= 1'b1;
      end
    end
  end

  assign dat_o     = rd_buf;
  assign ready_o   = (state == S_ACK) || (state == S_ERR);
  assign err_o     = (state == S_ERR);
  assign flash_ce  = (state != S_READ);
  assign flash_oe  = (state != S_READ);
  assign flash_we  = 1'b1;
  assign flash_rst = rst_n_i;

endmodule

// File: tb/tb_flash_rd_ctrl.sv
// Scoreboard bench for flash_rd_ctrl: randomized requests against a cache-level
// reference model, plus a directed 16-bit-flash instance.
module tb_flash_rd_ctrl;

  localparam int DW    = 8;
  localparam int WC    = 3;
  localparam int AW    = 22;
  localparam int BEATS = 32 / DW;
  localparam int LAT   = BEATS * WC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   adr;
  logic          stb, we, inv;
  logic [31:0]   dat;
  logic          ready, err;
  logic [AW-1:0] fadr;
  logic [DW-1:0] fdat;
  logic          ce, oe, fwe, frst;

  logic          rst16_n;
  logic [31:0]   adr16;
  logic          stb16, inv16;
  logic [31:0]   dat16;
  logic          ready16, err16;
  logic [AW-1:0] fadr16;
  logic [15:0]   fdat16;
  logic          ce16, oe16, fwe16, frst16;

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int unsigned at_cyc;
  } exp_t;
  exp_t q[$];

  bit            mvalid = 1'b0;
  logic [AW-3:0] mtag   = '0;

  flash_rd_ctrl #(.FLASH_DW(DW), .WAIT_CYC(WC), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr), .stb_i(stb), .we_i(we), .inv_i(inv),
    .dat_o(dat), .ready_o(ready), .err_o(err), .flash_adr_o(fadr), .flash_dat_i(fdat),
    .flash_ce(ce), .flash_oe(oe), .flash_we(fwe), .flash_rst(frst)
  );

  flash_rd_ctrl #(.FLASH_DW(16), .WAIT_CYC(2), .ADDR_W(AW)) dut16 (
    .clk_i(clk), .rst_n_i(rst16_n), .adr_i(adr16), .stb_i(stb16), .we_i(1'b0), .inv_i(inv16),
    .dat_o(dat16), .ready_o(ready16), .err_o(err16), .flash_adr_o(fadr16), .flash_dat_i(fdat16),
    .flash_ce(ce16), .flash_oe(oe16), .flash_we(fwe16), .flash_rst(frst16)
  );

  // Flash array contents, byte-addressed for the 8-bit part.
  function automatic logic [7:0] f8(input logic [AW-1:0] a);
    case (a)
      22'h100: return 8'h11;
      22'h101: return 8'h22;
      22'h102: return 8'h33;
      22'h103: return 8'h44;
      default: return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [15:0] f16(input logic [AW-1:0] a);
    case (a)
      22'h4:   return 16'hAAAA;
      22'h5:   return 16'h5555;
      default: return {a[7:0], ~a[7:0]};
    endcase
  endfunction

  function automatic logic [31:0] word8(input logic [AW-3:0] wi);
    logic [AW-1:0] b;
    b = AW'(wi) * AW'(4);
    return {f8(b), f8(b + 1), f8(b + 2), f8(b + 3)};
  endfunction

  always_comb fdat   = f8(fadr);
  always_comb fdat16 = f16(fadr16);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every response the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (ready || err)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_response: got ready=%b err=%b expected none (t=%0t)",
                 ready, err, $time);
      end else begin
        e = q.pop_front();
        check("resp_ready", {31'b0, ready}, 32'd1);
        check("resp_err", {31'b0, err}, {31'b0, e.is_err});
        check("resp_cycle", cyc, e.at_cyc);
        if (!e.is_err) check("resp_data", dat, e.data);
        check("flash_we_tied", {31'b0, fwe}, 32'd1);
        check("flash_rst_follows", {31'b0, frst}, 32'd1);
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input bit w, input bit inv0,
                        input int inv_k, input int abort_k);
    logic [AW-3:0] wi;
    logic [AW-1:0] exp_adr;
    bit            hit, miss, done, adr_ok;
    int unsigned   req;
    wi = a[AW-1:2];
    @(negedge clk);
    adr = a; we = w; inv = inv0; stb = 1'b1;
    req  = cyc + 1;
    hit  = !w && mvalid && (mtag == wi) && !inv0;
    miss = !w && !hit;
    if (inv0) mvalid = 1'b0;
    if (w) begin
      q.push_back('{is_err: 1'b1, data: 32'h0, at_cyc: req});
    end else if (hit) begin
      q.push_back('{is_err: 1'b0, data: word8(wi), at_cyc: req});
    end else begin
      if (abort_k == 0) q.push_back('{is_err: 1'b0, data: word8(wi), at_cyc: req + LAT});
      mvalid = (abort_k == 0) && !inv0 && !(inv_k >= 1 && inv_k <= LAT);
      mtag   = wi;
    end
    done   = 1'b0;
    adr_ok = 1'b1;
    for (int n = 1; n <= LAT + 20 && !done; n++) begin
      @(negedge clk);
      if (miss && n <= LAT && (abort_k == 0 || n <= abort_k)) begin
        exp_adr = AW'(wi) * AW'(BEATS) + AW'((n - 1) / WC);
        if (fadr !== exp_adr || ce !== 1'b0 || oe !== 1'b0) adr_ok = 1'b0;
      end
      if (ready) begin
        if (!miss) check("no_flash_access", {31'b0, ce}, 32'd1);
        stb = 1'b0; we = 1'b0; inv = 1'b0;
        done = 1'b1;
      end else if (miss && n == abort_k) begin
        stb = 1'b0; inv = 1'b0;
        @(negedge clk);
        check("ce_high_after_abort", {31'b0, ce}, 32'd1);
        repeat (3) @(negedge clk);
        done = 1'b1;
      end else begin
        inv = miss && (n == inv_k);
      end
    end
    if (miss) check("flash_adr_sequence", {31'b0, adr_ok}, 32'd1);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL response_timeout: got no ready_o expected one for adr %h", a);
      stb = 1'b0; we = 1'b0; inv = 1'b0;
    end
  endtask

  task automatic pulse_inv();
    @(negedge clk); inv = 1'b1;
    @(negedge clk); inv = 1'b0;
    mvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, ready}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_dat"}, dat, 32'd0);
    check({tag, "_fadr"}, {10'b0, fadr}, 32'd0);
    check({tag, "_ce_oe"}, {30'b0, ce, oe}, 32'd3);
    check({tag, "_frst"}, {31'b0, frst}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int unsigned req16, seen;
    logic [31:0] a;
    rst_n = 1'b0; rst16_n = 1'b0;
    adr = '0; stb = 1'b0; we = 1'b0; inv = 1'b0;
    adr16 = '0; stb16 = 1'b0; inv16 = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst16_n = 1'b1;

    // Directed sequence
    do_req(32'h100, 0, 0, 0, 0);   // miss, 12 cycles, 0x11223344
    do_req(32'h100, 0, 0, 0, 0);   // hit
    pulse_inv();
    do_req(32'h100, 0, 0, 0, 0);   // full fetch after invalidate
    do_req(32'h100, 0, 0, 5, 0);   // invalidated during fetch: not cached
    do_req(32'h100, 0, 0, 0, 0);   // fetch again, cached
    do_req(32'h200, 1, 0, 0, 0);   // write -> error
    do_req(32'h100, 0, 0, 0, 0);   // still a hit
    do_req(32'h104, 0, 0, 0, 5);   // aborted
    do_req(32'h104, 0, 0, 0, 0);   // full fetch
    do_req(32'h104, 0, 1, 0, 0);   // inv with request forces a fetch

    // Reset mid-read
    @(negedge clk); adr = 32'h108; we = 1'b0; inv = 1'b1; stb = 1'b1; mvalid = 1'b0;
    @(negedge clk); inv = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    stb = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_req(32'h108, 0, 0, 0, 0);   // buffer invalid after reset

    // Randomized phase
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = 32'h100;
        2:       a = 32'h104;
        3:       a = 32'h003F_FFFC;
        4:       a = 32'h200;
        default: a = $urandom & 32'h003F_FFFC;
      endcase
      a = a | ($urandom & 32'hFFC0_0003);
      do_req(a, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, LAT)) : 0,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, LAT)) : 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // 16-bit flash, 2 wait cycles: two beats, 4-cycle miss
    @(negedge clk); adr16 = 32'h8; stb16 = 1'b1; req16 = cyc + 1;
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(negedge clk);
      if (ready16) begin
        seen = 1;
        check("dw16_latency", cyc - req16, 32'd4);
        check("dw16_data", dat16, 32'hAAAA_5555);
        check("dw16_err", {31'b0, err16}, 32'd0);
        stb16 = 1'b0;
      end
    end
    check("dw16_ready_seen", seen, 32'd1);
    @(negedge clk); inv16 = 1'b1;
    @(negedge clk); inv16 = 1'b0;
    @(negedge clk); stb16 = 1'b1;
    seen = 0;
    @(negedge clk); if (ready16) seen++;
    @(negedge clk); if (ready16) seen++;
    rst16_n = 1'b0;
    #1;
    check("dw16_reset_out", {ready16, err16, ce16, oe16, frst16, 27'b0},
                            {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 27'b0});
    check("dw16_reset_dat", dat16, 32'd0);
    check("dw16_reset_fadr", {10'b0, fadr16}, 32'd0);
    stb16 = 1'b0;
    @(negedge clk); rst16_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ready16) seen++;
    end
    check("dw16_no_ready_after_reset", seen, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
